// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single memory port with data priority,
// bounded data bursts against a waiting fetch, and a per-transaction timeout.
module mem_arbiter #(
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned DW = $clog2(MAX_D_BURST + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT, RESP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] d_cnt_q, d_cnt_d;
  logic [TW-1:0] t_cnt_q, t_cnt_d;

  logic        mem_req_d, mem_we_d, if_ack_d, d_ack_d, err_d;
  logic [31:0] mem_addr_d, mem_wdata_d, if_rdata_d, d_rdata_d;
  logic [3:0]  mem_be_d;

  logic go_d, timeout;

  // Data wins unless a fetch is waiting and the data burst allowance is spent.
  assign go_d    = d_req && !(if_req && (d_cnt_q == DW'(MAX_D_BURST)));
  assign timeout = (t_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      d_cnt_q   <= '0;
      t_cnt_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      if_ack    <= 1'b0;
      d_rdata   <= '0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_cnt_q   <= d_cnt_d;
      t_cnt_q   <= t_cnt_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_be    <= mem_be_d;
      if_rdata  <= if_rdata_d;
      if_ack    <= if_ack_d;
      d_rdata   <= d_rdata_d;
      d_ack     <= d_ack_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go_d)        state_d = DGNT;
        else if (if_req) state_d = IGNT;
      end
      IGNT, DGNT: begin
        if (mem_ready || timeout) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Computes next values of every registered output from the current state.
  always_comb begin
    d_cnt_d     = d_cnt_q;
    t_cnt_d     = t_cnt_q;
    mem_req_d   = (state_d == IGNT) || (state_d == DGNT);
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go_d) begin
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          t_cnt_d     = '0;
          if (!if_req)                             d_cnt_d = '0;
          else if (d_cnt_q != DW'(MAX_D_BURST))    d_cnt_d = d_cnt_q + DW'(1);
        end else if (if_req) begin
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          mem_be_d   = 4'hF;
          t_cnt_d    = '0;
          d_cnt_d    = '0;
        end
      end
      IGNT, DGNT: begin
        if (mem_ready || timeout) begin
          // A ready on the timeout edge completes normally with real data.
          err_d = !mem_ready;
          if (state_q == IGNT) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_ready ? mem_rdata : '0;
          end
        end else begin
          t_cnt_d = t_cnt_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_D_BURST, default 4: maximum consecutive data grants while an instruction request waits.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles in a grant state before the transaction is aborted.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch request; held until if_ack.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  fetch read data; valid while if_ack=1.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  data request; held until d_ack.
REQ-010 d_we  in  1  1=write, 0=read.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  write data.
REQ-013 d_be  in  4  byte enables.
REQ-014 d_rdata  out  32  data read result; valid while d_ack=1.
REQ-015 d_ack  out  1  one-cycle data completion pulse.
REQ-016 err  out  1  one-cycle pulse, coincident with the ack of a timed-out transaction.
REQ-017 mem_req  out  1  memory request.
REQ-018 mem_we, mem_addr[31:0], mem_wdata[31:0], mem_be[3:0]  out  memory command, registered.
REQ-019 mem_rdata  in  32  memory read data; sampled when mem_ready=1.
REQ-020 mem_ready  in  1  memory completion; may be asserted in the first cycle of mem_req.

Function
REQ-021 FSM states SHALL be IDLE, IGNT, DGNT and RESP; all outputs SHALL be registered.
REQ-022 IDLE SHALL select DGNT if d_req=1 and not (if_req=1 and d_cnt==MAX_D_BURST); otherwise IGNT if if_req=1; otherwise stay in IDLE.
REQ-023 On entering IGNT, the arbiter SHALL latch mem_addr=if_addr, mem_we=0, mem_be=4'hF.
REQ-024 On entering DGNT, the arbiter SHALL latch d_addr, d_we, d_wdata and d_be onto the mem_* outputs.
REQ-025 mem_req SHALL be 1 exactly while the state is IGNT or DGNT.
REQ-026 The mem_* command SHALL stay stable until the transaction completes.
REQ-027 In IGNT or DGNT, a clock edge with mem_ready=1 SHALL move the FSM to RESP, capture mem_rdata into the granted requester's rdata register and set that requester's ack.
REQ-028 RESP SHALL last exactly one cycle, with ack=1; the FSM then returns to IDLE.
REQ-029 Minimum request-to-ack latency SHALL be 2 cycles: IDLE edge to grant, then grant with mem_ready=1 to RESP. Minimum spacing is one transaction per 3 cycles.
REQ-030 d_cnt SHALL increment, saturating at MAX_D_BURST, on each DGNT entry made while if_req=1. It SHALL clear on IGNT entry, or on DGNT entry made while if_req=0.
REQ-031 A timeout counter SHALL clear on grant entry and increment each grant cycle without mem_ready. On reaching TIMEOUT, the FSM SHALL enter RESP with rdata=0 and err=1 for that cycle.
REQ-032 If mem_ready=1 arrives on the same edge as the timeout, mem_ready SHALL win: normal completion, err=0.
REQ-033 If req drops during a grant, the transaction SHALL still complete and ack SHALL still pulse.
REQ-034 Reads SHALL leave rdata of the non-granted requester unchanged; writes SHALL return rdata=mem_rdata as sampled.
REQ-035 If d_req=1 and if_req=1 both arrive in IDLE with d_cnt<MAX_D_BURST, data SHALL win.

Reset
REQ-036 rst=0 SHALL immediately force state=IDLE.
REQ-037 rst=0 SHALL immediately force mem_req=0, if_ack=0, d_ack=0, err=0.
REQ-038 rst=0 SHALL immediately force all data, address and be outputs to 0, and d_cnt and the timeout counter to 0.
REQ-039 Reset mid-transaction SHALL abort the transaction with no ack; reset release SHALL take effect on the next rising edge.

Verification
REQ-040 Single fetch: if_req=1, if_addr=0x00400000, mem_ready=1 in the first grant cycle, mem_rdata=0x8C080004 -> mem_req high 1 cycle; if_ack=1 two cycles after the request, with if_rdata=0x8C080004.
REQ-041 Data write: d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_* carry these values; d_ack pulses once; err=0.
REQ-042 Starvation: d_req and if_req held continuously -> exactly 4 data grants, then 1 fetch grant, repeating.
REQ-043 Timeout: d_req=1, mem_ready held at 0 -> after 255 grant cycles, d_ack=1, err=1, d_rdata=0.
REQ-044 Mid-grant reset: rst=0 during DGNT -> same cycle mem_req=0, no d_ack; after release, a new if_req is served normally.
REQ-045 Timeout race: mem_ready=1 on the 255th grant cycle -> normal ack with err=0.
